// File: rtl/spike_count_decoder_if.sv
// Handshake/data bundle between an upstream spiking layer (master) and spike_count_decoder (slave).
// Build option SPIKE_DECODER_ABORT_EN adds the abort request line.
interface spike_count_decoder_if #(
    parameter int NUM_NEURONS = 8,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 3
);
    logic                   start;
    logic [NUM_NEURONS-1:0] spike_in;
    logic                   spike_valid;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ready;
    logic [IDX_W-1:0]       winner_idx;
    logic [CNT_W-1:0]       winner_count;
    logic                   tie;
`ifdef SPIKE_DECODER_ABORT_EN
    logic                   abort;

    modport master (
        output start, spike_in, spike_valid, result_ready, abort,
        input  busy, result_valid, winner_idx, winner_count, tie
    );
    modport slave (
        input  start, spike_in, spike_valid, result_ready, abort,
        output busy, result_valid, winner_idx, winner_count, tie
    );
`else
    modport master (
        output start, spike_in, spike_valid, result_ready,
        input  busy, result_valid, winner_idx, winner_count, tie
    );
    modport slave (
        input  start, spike_in, spike_valid, result_ready,
        output busy, result_valid, winner_idx, winner_count, tie
    );
`endif
endinterface

// File: rtl/spike_count_decoder.sv
// Windowed spike counter + sequential argmax decoder for an 8-neuron LIF layer output.
// Build option SPIKE_DECODER_ABORT_EN adds an abort input that cancels an ACCUM/ARGMAX window.
module spike_count_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module spike_count_decoder #(
    parameter int NUM_NEURONS = 8,
    parameter int CNT_W       = 8,
    parameter int WINDOW      = 16,
    parameter int IDX_W       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    spike_count_decoder_if.slave bus
);
    localparam int TS_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, HOLD} state_e;

    state_e                            state_q, state_d;
    logic [TS_W-1:0]                   ts_q, ts_d;
    logic [IDX_W-1:0]                  scan_q, scan_d;
    logic [IDX_W-1:0]                  win_idx_q, win_idx_d;
    logic [CNT_W-1:0]                  win_cnt_q, win_cnt_d;
    logic                              tie_q, tie_d;
    logic                              clr, acc_en, abort_req;
    logic [NUM_NEURONS-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]                  cur_cnt;

`ifdef SPIKE_DECODER_ABORT_EN
    assign abort_req = bus.abort && ((state_q == ACCUM) || (state_q == ARGMAX));
`else
    assign abort_req = 1'b0;
`endif

    // Abort wins over a same-cycle valid timestep.
    assign acc_en  = (state_q == ACCUM) && bus.spike_valid && !abort_req;
    assign cur_cnt = cnt[scan_q];

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
        spike_count_lane #(.CNT_W(CNT_W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr_i (clr),
            .inc_i (acc_en && bus.spike_in[i]),
            .cnt_o (cnt[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        scan_d    = scan_q;
        win_idx_d = win_idx_q;
        win_cnt_d = win_cnt_q;
        tie_d     = tie_q;
        clr       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    ts_d    = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (acc_en) begin
                    ts_d = ts_q + TS_W'(1);
                    if (ts_q == TS_W'(WINDOW - 1)) begin
                        scan_d  = '0;
                        state_d = ARGMAX;
                    end
                end
            end
            ARGMAX: begin
                // Strict '>' keeps the lowest index on ties.
                if ((scan_q == '0) || (cur_cnt > win_cnt_q)) begin
                    win_idx_d = scan_q;
                    win_cnt_d = cur_cnt;
                    tie_d     = 1'b0;
                end else if (cur_cnt == win_cnt_q) begin
                    tie_d = 1'b1;
                end
                scan_d = scan_q + IDX_W'(1);
                if (scan_q == IDX_W'(NUM_NEURONS - 1))
                    state_d = HOLD;
            end
            HOLD: begin
                if (bus.result_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_req) begin
            clr       = 1'b1;
            ts_d      = '0;
            scan_d    = '0;
            win_idx_d = win_idx_q;
            win_cnt_d = win_cnt_q;
            tie_d     = tie_q;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ts_q      <= '0;
            scan_q    <= '0;
            win_idx_q <= '0;
            win_cnt_q <= '0;
            tie_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            scan_q    <= scan_d;
            win_idx_q <= win_idx_d;
            win_cnt_q <= win_cnt_d;
            tie_q     <= tie_d;
        end
    end

    assign bus.busy         = (state_q == ACCUM) || (state_q == ARGMAX);
    assign bus.result_valid = (state_q == HOLD);
    assign bus.winner_idx   = win_idx_q;
    assign bus.winner_count = win_cnt_q;
    assign bus.tie          = tie_q;
endmodule

// File: tb/tb_spike_count_decoder.sv
// Directed bench for spike_count_decoder: one default DUT and one CNT_W=4 DUT driven in lockstep.
// Build option SPIKE_DECODER_ABORT_EN adds the abort scenario.
module tb_spike_count_decoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       start, spike_valid, result_ready;
    logic [7:0] spike_in;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         lat;
    bit         seen;
`ifdef SPIKE_DECODER_ABORT_EN
    logic       abort;
`endif

    always #5 clk = ~clk;

    spike_count_decoder_if #(.NUM_NEURONS(8), .CNT_W(8), .IDX_W(3)) bus8 ();
    spike_count_decoder_if #(.NUM_NEURONS(8), .CNT_W(4), .IDX_W(3)) bus4 ();

    assign bus8.start        = start;
    assign bus8.spike_in     = spike_in;
    assign bus8.spike_valid  = spike_valid;
    assign bus8.result_ready = result_ready;
    assign bus4.start        = start;
    assign bus4.spike_in     = spike_in;
    assign bus4.spike_valid  = spike_valid;
    assign bus4.result_ready = result_ready;
`ifdef SPIKE_DECODER_ABORT_EN
    assign bus8.abort = abort;
    assign bus4.abort = abort;
`endif

    spike_count_decoder #(.NUM_NEURONS(8), .CNT_W(8), .WINDOW(16), .IDX_W(3)) u_dut8 (
        .clk(clk), .reset(reset), .bus(bus8)
    );
    spike_count_decoder #(.NUM_NEURONS(8), .CNT_W(4), .WINDOW(16), .IDX_W(3)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Per-test spike pattern for timestep t.
    function automatic logic [7:0] pat(input int tc, input int t);
        case (tc)
            1: return 8'h04;
            2: return 8'h00;
            3: return (t < 4) ? 8'h29 : ((t < 10) ? 8'h28 : 8'h00);
            4: return (t < 14) ? 8'h81 : 8'h80;
            5: return (t % 2 == 0) ? 8'h42 : 8'h02;
            6: return (t < 8) ? 8'h14 : 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    task automatic run_window(input int tc, input bit gap);
        for (int t = 0; t < 16; t++) begin
            spike_valid = 1'b1;
            spike_in    = pat(tc, t);
            tick();
            if (gap && t < 15) begin
                spike_valid = 1'b0;
                spike_in    = 8'hFF;
                tick();
            end
        end
        spike_valid = 1'b0;
        spike_in    = 8'h00;
    endtask

    task automatic wait_result(input bit junk, output int n);
        n           = 0;
        spike_valid = junk;
        spike_in    = 8'hFF;
        while (!bus8.result_valid && n < 40) begin
            tick();
            n++;
        end
        spike_valid = 1'b0;
        spike_in    = 8'h00;
    endtask

    task automatic check_result(input string tag, input int idx, input int cnt, input int tie_e);
        chk({tag, ".rv"},  bus8.result_valid, 1);
        chk({tag, ".idx"}, bus8.winner_idx,   idx);
        chk({tag, ".cnt"}, bus8.winner_count, cnt);
        chk({tag, ".tie"}, bus8.tie,          tie_e);
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, ".hs_rv"},   bus8.result_valid, 0);
        chk({tag, ".hs_busy"}, bus8.busy,         0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; spike_valid = 1'b0; spike_in = 8'h00; result_ready = 1'b0;
`ifdef SPIKE_DECODER_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        chk("rst.busy", bus8.busy,         0);
        chk("rst.rv",   bus8.result_valid, 0);
        chk("rst.idx",  bus8.winner_idx,   0);
        chk("rst.cnt",  bus8.winner_count, 0);
        chk("rst.tie",  bus8.tie,          0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // spike_valid while idle must not start anything
        spike_valid = 1'b1; spike_in = 8'hFF; tick(); spike_valid = 1'b0;
        chk("idle.busy", bus8.busy, 0);

        // 1: single active neuron, latency
        pulse_start();
        chk("t1.busy", bus8.busy, 1);
        run_window(1, 1'b0);
        chk("t1.busy_scan", bus8.busy, 1);
        wait_result(1'b0, lat);
        chk("t1.lat", lat, 8);
        check_result("t1", 2, 16, 0);
        chk("t1.busy_hold", bus8.busy, 0);
        handshake("t1");
        chk("t1.keep_cnt", bus8.winner_count, 16);

        // 2: all-zero window
        pulse_start();
        run_window(2, 1'b0);
        wait_result(1'b0, lat);
        chk("t2.lat", lat, 8);
        check_result("t2", 0, 0, 1);
        handshake("t2");

        // 3: tie between 3 and 5; junk spikes during ARGMAX are dropped
        pulse_start();
        run_window(3, 1'b0);
        wait_result(1'b1, lat);
        chk("t3.lat", lat, 8);
        check_result("t3", 3, 10, 1);
        handshake("t3");

        // 4: saturation in the 4-bit DUT
        pulse_start();
        run_window(4, 1'b0);
        wait_result(1'b0, lat);
        check_result("t4", 7, 16, 0);
        chk("t4.c4_rv",  bus4.result_valid, 1);
        chk("t4.c4_idx", bus4.winner_idx,   7);
        chk("t4.c4_cnt", bus4.winner_count, 15);
        chk("t4.c4_tie", bus4.tie,          0);
        handshake("t4");

        // 5: gapped valids, backpressure with start pulses in HOLD
        pulse_start();
        run_window(5, 1'b1);
        wait_result(1'b0, lat);
        chk("t5.lat", lat, 8);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            tick();
        end
        start = 1'b0;
        check_result("t5", 1, 16, 0);
        chk("t5.busy", bus8.busy, 0);
        start = 1'b1; result_ready = 1'b1;
        tick();
        start = 1'b0; result_ready = 1'b0;
        chk("t5.hs_rv",   bus8.result_valid, 0);
        chk("t5.hs_busy", bus8.busy,         0);
        tick();
        chk("t5.idle_busy", bus8.busy, 0);
        pulse_start();
        chk("t5.restart", bus8.busy, 1);

        // 6: reset mid-window, then a clean window
        for (int t = 0; t < 7; t++) begin
            spike_valid = 1'b1; spike_in = 8'hFF; tick();
        end
        spike_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6.busy", bus8.busy,         0);
        chk("t6.rv",   bus8.result_valid, 0);
        chk("t6.cnt",  bus8.winner_count, 0);
        tick();
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus8.result_valid || bus8.busy) seen = 1'b1;
        end
        chk("t6.quiet", seen, 0);
        pulse_start();
        run_window(6, 1'b0);
        wait_result(1'b0, lat);
        chk("t6.lat", lat, 8);
        check_result("t6", 4, 16, 0);
        handshake("t6");

`ifdef SPIKE_DECODER_ABORT_EN
        // abort mid-window, coincident with a valid timestep
        pulse_start();
        for (int t = 0; t < 7; t++) begin
            spike_valid = 1'b1; spike_in = 8'hFF; tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; spike_valid = 1'b0;
        chk("ab.busy", bus8.busy, 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus8.result_valid) seen = 1'b1;
        end
        chk("ab.quiet", seen, 0);
        pulse_start();
        run_window(1, 1'b0);
        wait_result(1'b0, lat);
        chk("ab.lat", lat, 8);
        check_result("ab", 2, 16, 0);
        handshake("ab");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
